// File: rtl/reu_pkg.sv
// Shared definitions for the REU timing blocks.
//   lock_state_t  : state of the PHI2 lock tracker
//   DEF_MIN_PER / DEF_MAX_PER : default accepted PHI2 period window (C8M cycles)
//   C8M_PER_PHI2  : nominal number of C8M cycles per PHI2 period
package reu_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } lock_state_t;

  localparam int DEF_MIN_PER  = 7;
  localparam int DEF_MAX_PER  = 9;
  localparam int C8M_PER_PHI2 = 8;

endpackage

// File: rtl/sync2_edge.sv
// Two-flop synchroniser with rise/fall detection of the synchronised level.
// Reusable for any slow asynchronous level (PHI2, BA, nRESET).
//   clk   : destination clock
//   rst_n : asynchronous active-low reset
//   din   : asynchronous input level
//   dout  : synchronised level (second flop)
//   rise  : one-cycle pulse when dout goes 0->1
//   fall  : one-cycle pulse when dout goes 1->0
module sync2_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign dout = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/phi2_phase_tracker.sv
// Locks the C8M domain to the C64 PHI2 clock: measures the PHI2 period,
// keeps a phase counter, declares lock, and produces the SDRAM command
// slots and the refresh request/acknowledge bookkeeping.
//   C8M        : 8 MHz clock (sole clock)
//   nRESET     : asynchronous active-low reset
//   PHI2       : C64 PHI2, asynchronous
//   PHI2s      : synchronised PHI2
//   Phi2Rise   : pulse on synchronised rising edge
//   Phi2Fall   : pulse on synchronised falling edge
//   Phase      : C8M cycles since last Phi2Rise (saturates at 15)
//   PeriodLast : length of last complete PHI2 period (saturates at 15)
//   Locked     : tracker locked
//   RdSlot     : read-command slot pulse
//   WrSlot     : write-command slot pulse
//   RefReq     : refresh request level (RefPend != 0)
//   RefAck     : refresh accepted pulse from RAM
//   RefPend    : outstanding refresh count (saturates at 7)
module phi2_phase_tracker
  import reu_pkg::*;
#(
  parameter int MIN_PER  = DEF_MIN_PER,
  parameter int MAX_PER  = DEF_MAX_PER,
  parameter int LOCK_CNT = 4,
  parameter int RD_PH    = 2,
  parameter int WR_PH    = 5,
  parameter int REF_DIV  = 15
) (
  input  logic       C8M,
  input  logic       nRESET,
  input  logic       PHI2,
  output logic       PHI2s,
  output logic       Phi2Rise,
  output logic       Phi2Fall,
  output logic [3:0] Phase,
  output logic [3:0] PeriodLast,
  output logic       Locked,
  output logic       RdSlot,
  output logic       WrSlot,
  output logic       RefReq,
  input  logic       RefAck,
  output logic [2:0] RefPend
);

  // Phase value 15 doubles as the "PHI2 stopped" marker, so the accepted
  // window must stay below it, and the slots must be distinct phases.
  if (RD_PH == WR_PH) begin : g_chk_slots
    $error("RD_PH and WR_PH must select different phases");
  end
  if (MIN_PER < 1 || MAX_PER > 14 || MIN_PER > MAX_PER) begin : g_chk_window
    $error("period window must satisfy 1 <= MIN_PER <= MAX_PER <= 14");
  end
  if (C8M_PER_PHI2 < MIN_PER || C8M_PER_PHI2 > MAX_PER) begin : g_chk_nominal
    $error("nominal C8M/PHI2 ratio lies outside the accepted window");
  end
  if (LOCK_CNT < 1 || LOCK_CNT > 7) begin : g_chk_lock
    $error("LOCK_CNT must be 1..7");
  end
  if (REF_DIV < 1 || REF_DIV > 255) begin : g_chk_ref
    $error("REF_DIV must be 1..255");
  end

  localparam logic [3:0] MIN_P    = 4'(MIN_PER);
  localparam logic [3:0] MAX_P    = 4'(MAX_PER);
  localparam logic [3:0] RD_P     = 4'(RD_PH);
  localparam logic [3:0] WR_P     = 4'(WR_PH);
  localparam logic [2:0] LOCK_N   = 3'(LOCK_CNT);
  localparam logic [7:0] REF_LAST = 8'(REF_DIV - 1);

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? 4'hF : v + 4'd1;
  endfunction

  // Simultaneous due and acknowledge cancel out; acknowledges with nothing
  // outstanding are dropped.
  function automatic logic [2:0] pend_update(input logic [2:0] p,
                                             input logic       d,
                                             input logic       a);
    if (d && !a) return (p == 3'd7) ? p : p + 3'd1;
    if (a && !d) return (p == 3'd0) ? p : p - 3'd1;
    return p;
  endfunction

  lock_state_t state;
  logic [2:0]  good_cnt;
  logic [7:0]  ref_div;
  logic [3:0]  period_new;
  logic        good;
  logic        timeout;
  logic        due;
  logic [2:0]  pend_next;

  // ---- synchronisation stage ----
  sync2_edge u_sync (
    .clk  (C8M),
    .rst_n(nRESET),
    .din  (PHI2),
    .dout (PHI2s),
    .rise (Phi2Rise),
    .fall (Phi2Fall)
  );

  // ---- phase / period measurement ----
  assign period_new = sat_inc4(Phase);
  assign good       = (period_new >= MIN_P) && (period_new <= MAX_P);
  assign timeout    = (Phase == 4'hF);

  always_ff @(posedge C8M or negedge nRESET) begin
    if (!nRESET) begin
      Phase      <= 4'hF;
      PeriodLast <= 4'd0;
    end else if (Phi2Rise) begin
      Phase      <= 4'd0;
      PeriodLast <= period_new;
    end else begin
      Phase      <= sat_inc4(Phase);
    end
  end

  // ---- lock tracking ----
  // A rise always takes priority over the stopped-clock timeout: the first
  // rise after reset or after a stall arrives with Phase already at 15.
  always_ff @(posedge C8M or negedge nRESET) begin
    if (!nRESET) begin
      state    <= UNLOCKED;
      good_cnt <= 3'd0;
      Locked   <= 1'b0;
    end else if (Phi2Rise) begin
      unique case (state)
        UNLOCKED: begin
          state    <= ACQUIRE;
          good_cnt <= 3'd0;
          Locked   <= 1'b0;
        end
        ACQUIRE: begin
          if (!good) begin
            good_cnt <= 3'd0;
          end else if (good_cnt + 3'd1 == LOCK_N) begin
            state    <= LOCKED;
            good_cnt <= 3'd0;
            Locked   <= 1'b1;
          end else begin
            good_cnt <= good_cnt + 3'd1;
          end
        end
        LOCKED: begin
          if (!good) begin
            state    <= ACQUIRE;
            good_cnt <= 3'd0;
            Locked   <= 1'b0;
          end
        end
        default: begin
          state    <= UNLOCKED;
          good_cnt <= 3'd0;
          Locked   <= 1'b0;
        end
      endcase
    end else if (timeout) begin
      state    <= UNLOCKED;
      good_cnt <= 3'd0;
      Locked   <= 1'b0;
    end
  end

  // ---- command slots ----
  assign RdSlot = Locked && (Phase == RD_P);
  assign WrSlot = Locked && (Phase == WR_P);

  // ---- refresh scheduling ----
  // Losing lock restarts the divider but the pending count is kept: those
  // refreshes are still owed to the SDRAM.
  assign due       = Locked && Phi2Rise && (ref_div == REF_LAST);
  assign pend_next = pend_update(RefPend, due, RefAck);

  always_ff @(posedge C8M or negedge nRESET) begin
    if (!nRESET) begin
      ref_div <= 8'd0;
      RefPend <= 3'd0;
      RefReq  <= 1'b0;
    end else begin
      if (!Locked) begin
        ref_div <= 8'd0;
      end else if (Phi2Rise) begin
        ref_div <= (ref_div == REF_LAST) ? 8'd0 : ref_div + 8'd1;
      end
      RefPend <= pend_next;
      RefReq  <= (pend_next != 3'd0);
    end
  end

endmodule

// File: tb/tb_phi2_phase_tracker.sv
module tb_phi2_phase_tracker;

  logic       C8M;
  logic       nRESET;
  logic       PHI2;
  logic       PHI2s;
  logic       Phi2Rise;
  logic       Phi2Fall;
  logic [3:0] Phase;
  logic [3:0] PeriodLast;
  logic       Locked;
  logic       RdSlot;
  logic       WrSlot;
  logic       RefReq;
  logic       RefAck;
  logic [2:0] RefPend;

  phi2_phase_tracker dut (
    .C8M       (C8M),
    .nRESET    (nRESET),
    .PHI2      (PHI2),
    .PHI2s     (PHI2s),
    .Phi2Rise  (Phi2Rise),
    .Phi2Fall  (Phi2Fall),
    .Phase     (Phase),
    .PeriodLast(PeriodLast),
    .Locked    (Locked),
    .RdSlot    (RdSlot),
    .WrSlot    (WrSlot),
    .RefReq    (RefReq),
    .RefAck    (RefAck),
    .RefPend   (RefPend)
  );

  initial C8M = 1'b0;
  always #5 C8M = ~C8M;

  // Expected observation for one PHI2 rise: PeriodLast and Locked in the
  // cycle after the rise, and the slot pulses seen since the previous rise.
  typedef struct {
    int per;
    int lock;
    int rd;
    int wr;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One PHI2 period of n C8M cycles, starting with a rise; optional RefAck
  // pulse landing in the cycle where the DUT sees that rise.
  task automatic period(input int n, input int ep, input int el,
                        input int erd, input int ewr, input bit ack);
    exp_t e;
    e.per = ep; e.lock = el; e.rd = erd; e.wr = ewr;
    sb.push_back(e);
    PHI2 = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i == (n + 1) / 2) PHI2 = 1'b0;
      if (i == 2) RefAck = ack;
      if (i == 3) RefAck = 1'b0;
      @(negedge C8M);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_phi2s"},      PHI2s,      0);
    chk({tag, "_rise"},       Phi2Rise,   0);
    chk({tag, "_fall"},       Phi2Fall,   0);
    chk({tag, "_phase"},      Phase,      15);
    chk({tag, "_periodlast"}, PeriodLast, 0);
    chk({tag, "_locked"},     Locked,     0);
    chk({tag, "_rdslot"},     RdSlot,     0);
    chk({tag, "_wrslot"},     WrSlot,     0);
    chk({tag, "_refreq"},     RefReq,     0);
    chk({tag, "_refpend"},    RefPend,    0);
  endtask

  task automatic lock_sequence();
    period(8, 15, 0, 0, 0, 0);
    repeat (3) period(8, 8, 0, 0, 0, 0);
    period(8, 8, 1, 0, 0, 0);
    chk("lock_periodlast", PeriodLast, 8);
    period(8, 8, 1, 1, 1, 0);
  endtask

  // Monitor: pops one expectation per observed Phi2Rise.
  initial begin
    exp_t cur;
    bit   pend_chk;
    int   rd_cnt;
    int   wr_cnt;
    pend_chk = 1'b0;
    rd_cnt = 0;
    wr_cnt = 0;
    forever begin
      @(negedge C8M);
      if (!mon_en) begin
        pend_chk = 1'b0;
        rd_cnt = 0;
        wr_cnt = 0;
      end else begin
        if (pend_chk) begin
          chk("sb_periodlast", PeriodLast, cur.per);
          chk("sb_locked", Locked, cur.lock);
          pend_chk = 1'b0;
        end
        if (Phi2Rise) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_underflow: unexpected Phi2Rise at t=%0t", $time);
          end else begin
            cur = sb.pop_front();
            chk("sb_rdslot_count", rd_cnt, cur.rd);
            chk("sb_wrslot_count", wr_cnt, cur.wr);
            pend_chk = 1'b1;
          end
          rd_cnt = 0;
          wr_cnt = 0;
        end else begin
          rd_cnt += int'(RdSlot);
          wr_cnt += int'(WrSlot);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  int jit_n[8];
  int jit_ep[8];
  int found;

  initial begin
    jit_n  = '{7, 9, 7, 9, 7, 9, 7, 9};
    jit_ep = '{8, 7, 9, 7, 9, 7, 9, 7};
    nRESET = 1'b0;
    PHI2   = 1'b0;
    RefAck = 1'b0;
    repeat (3) @(negedge C8M);
    chk_reset_vals("rst0");
    nRESET = 1'b1;
    mon_en = 1'b1;
    @(negedge C8M);

    // Stable 8-cycle PHI2: lock on the 5th rise, then accumulate refreshes.
    lock_sequence();
    for (int k = 7; k <= 125; k++) period(8, 8, 1, 1, 1, 0);
    chk("refpend_saturated", RefPend, 7);
    chk("refreq_saturated", RefReq, 1);
    period(8, 8, 1, 1, 1, 1);
    chk("refpend_after_ack", RefPend, 6);
    repeat (5) period(8, 8, 1, 1, 1, 1);
    chk("refpend_drained_to_1", RefPend, 1);
    repeat (8) period(8, 8, 1, 1, 1, 0);
    period(8, 8, 1, 1, 1, 1);
    chk("refpend_due_and_ack", RefPend, 1);
    chk("refreq_due_and_ack", RefReq, 1);
    repeat (15) period(8, 8, 1, 1, 1, 0);
    chk("refpend_two", RefPend, 2);

    // Jitter 7/9 keeps lock; one period of 11 drops it.
    for (int j = 0; j < 8; j++) period(jit_n[j], jit_ep[j], 1, 1, 1, 0);
    chk("jitter_locked", Locked, 1);
    period(11, 9, 1, 1, 1, 0);
    period(8, 11, 0, 1, 1, 0);
    chk("lost_locked", Locked, 0);
    chk("lost_refpend", RefPend, 2);
    chk("lost_refreq", RefReq, 1);
    period(8, 8, 0, 0, 0, 1);
    chk("lost_refpend_ack1", RefPend, 1);
    chk("lost_refreq_ack1", RefReq, 1);
    period(8, 8, 0, 0, 0, 1);
    chk("lost_refpend_ack2", RefPend, 0);
    chk("lost_refreq_ack2", RefReq, 0);
    period(8, 8, 0, 0, 0, 0);
    period(8, 8, 1, 0, 0, 0);
    period(8, 8, 1, 1, 1, 0);

    // PHI2 stalls high while locked.
    sb.push_back('{8, 1, 1, 1});
    PHI2 = 1'b1;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge C8M);
      if (Phase == 4'hF) found = 1;
    end
    chk("stall_phase_reaches_15", found, 1);
    chk("stall_locked_at_sat", Locked, 1);
    @(negedge C8M);
    chk("stall_locked_next", Locked, 0);
    repeat (8) @(negedge C8M);
    chk("stall_phase_held", Phase, 15);
    PHI2 = 1'b0;
    repeat (4) @(negedge C8M);
    period(8, 15, 0, 1, 1, 0);
    repeat (3) period(8, 8, 0, 0, 0, 0);
    period(8, 8, 1, 0, 0, 0);
    period(8, 8, 1, 1, 1, 0);

    // Asynchronous reset in the middle of a locked period.
    mon_en = 1'b0;
    PHI2 = 1'b1;
    repeat (5) @(negedge C8M);
    chk("pre_rst_locked", Locked, 1);
    chk("pre_rst_phi2s", PHI2s, 1);
    #2;
    nRESET = 1'b0;
    #1;
    chk_reset_vals("rst_mid");
    repeat (3) @(negedge C8M);
    PHI2 = 1'b0;
    repeat (2) @(negedge C8M);
    nRESET = 1'b1;
    mon_en = 1'b1;
    @(negedge C8M);
    lock_sequence();

    repeat (3) @(negedge C8M);
    chk("sb_leftover", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
